dac_frame_sequencer: RTL and testbench

//  Upstream feeder for the SPI DAC write stage. Buffers paired channel-A/B samples in a small FIFO.

---
 rtl/dac_frame_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_dac_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer
// Feeds the SPI DAC write stage: buffers channel A/B sample pairs, turns each
// pair into two 16-bit DAC command words, sends them one after the other, and
// then pulses ldac_n so that both DAC outputs update together.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | wait for a buffered pair; pop it and latch both command words
// SEND_A | present word A, one-cycle spi_start
// WAIT_A | hold word A until spi_done or the wait timer expires
// SEND_B | present word B, one-cycle spi_start
// WAIT_B | hold word B until spi_done or the wait timer expires
// LDAC   | drive ldac_n low for LDAC_CYCLES cycles, count the frame
module dac_frame_sequencer #(
  parameter int DATA_W      = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int LDAC_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2*DATA_W-1:0] s_data,
  input  logic                gain_1x,
  input  logic                buffered,
  input  logic                shdn,
  output logic [15:0]         spi_word,
  output logic                spi_start,
  input  logic                spi_done,
  output logic                ldac_n,
  output logic [15:0]         frames_sent,
  output logic                err_timeout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int LDC_W = $clog2(LDAC_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    WAIT_A = 3'd2,
    SEND_B = 3'd3,
    WAIT_B = 3'd4,
    LDAC   = 3'd5
  } state_t;

  state_t state, state_next;

  logic [2*DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic [15:0]         word_a;
  logic [15:0]         word_b;

  logic [TMR_W-1:0]    wait_tmr;
  logic                wait_load;
  logic [LDC_W-1:0]    ldac_tmr;
  logic                ldac_load;
  logic                frame_done;
  logic                timeout_hit;
  logic                in_wait;

  logic [15:0]         frames_q;
  logic                err_q;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a slot early; it is also held low while reset is asserted.
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign s_ready    = ~reset & ~fifo_full;
  assign push       = s_valid & s_ready;
  assign in_wait    = (state == WAIT_A) || (state == WAIT_B);

  assign frames_sent = frames_q;
  assign err_timeout = err_q;

  // Sample storage; entries need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Latch both command words at pop; control bits are frozen for the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_a <= '0;
      word_b <= '0;
    end else if (pop) begin
      word_a <= {1'b0, buffered, gain_1x, ~shdn, fifo_mem[rd_ptr][DATA_W-1:0]};
      word_b <= {1'b1, buffered, gain_1x, ~shdn, fifo_mem[rd_ptr][2*DATA_W-1:DATA_W]};
    end
  end

  // spi_done wait timer: loaded when a word is launched, counts down in WAIT_x.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_tmr <= '0;
    end else if (wait_load) begin
      wait_tmr <= TMR_W'(TIMEOUT - 1);
    end else if (in_wait && (wait_tmr != '0)) begin
      wait_tmr <= wait_tmr - TMR_W'(1);
    end
  end

  // ldac_n low-time timer: loaded on the way into LDAC, counts down there.
  always_ff @(posedge clk) begin
    if (reset) begin
      ldac_tmr <= '0;
    end else if (ldac_load) begin
      ldac_tmr <= LDC_W'(LDAC_CYCLES - 1);
    end else if ((state == LDAC) && (ldac_tmr != '0)) begin
      ldac_tmr <= ldac_tmr - LDC_W'(1);
    end
  end

  // Completed-frame counter (wraps naturally) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (frame_done) begin
        frames_q <= frames_q + 16'd1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and Moore outputs; spi_word is zero outside a transfer.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    wait_load   = 1'b0;
    ldac_load   = 1'b0;
    frame_done  = 1'b0;
    timeout_hit = 1'b0;
    spi_start   = 1'b0;
    spi_word    = '0;
    ldac_n      = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = SEND_A;
        end
      end
      SEND_A: begin
        spi_word   = word_a;
        spi_start  = 1'b1;
        wait_load  = 1'b1;
        state_next = WAIT_A;
      end
      WAIT_A: begin
        spi_word = word_a;
        if (spi_done) begin
          state_next = SEND_B;
        end else if (wait_tmr == '0) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      SEND_B: begin
        spi_word   = word_b;
        spi_start  = 1'b1;
        wait_load  = 1'b1;
        state_next = WAIT_B;
      end
      WAIT_B: begin
        spi_word = word_b;
        if (spi_done) begin
          ldac_load  = 1'b1;
          state_next = LDAC;
        end else if (wait_tmr == '0) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      LDAC: begin
        ldac_n = 1'b0;
        if (ldac_tmr == '0) begin
          frame_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: a table of single frames plus
// directed sequences for back-pressure, timeout, mid-frame reset and wrap.
module tb_dac_frame_sequencer;

  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic              s_ready;
  logic [2*DATA_W-1:0] s_data;
  logic              gain_1x;
  logic              buffered;
  logic              shdn;
  logic [15:0]       spi_word;
  logic              spi_start;
  logic              spi_done;
  logic              ldac_n;
  logic [15:0]       frames_sent;
  logic              err_timeout;

  always #5 clk = ~clk;

  dac_frame_sequencer #(
    .DATA_W(12), .FIFO_DEPTH(4), .LDAC_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .gain_1x(gain_1x), .buffered(buffered), .shdn(shdn),
    .spi_word(spi_word), .spi_start(spi_start), .spi_done(spi_done),
    .ldac_n(ldac_n), .frames_sent(frames_sent), .err_timeout(err_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] word_log[$];
  int          frame_cyc_q[$];
  int          start_first = -1;
  int          ldac_low = 0;
  int          ldac_pulses = 0;
  logic        ldac_prev = 1'b1;
  logic [15:0] frames_prev = '0;
  bit          resp_en = 1'b1;
  int          resp_delay = 16;
  int          resp_cnt = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        gain;
    logic        buff;
    logic        sd;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample on the falling edge, log activity, model the SPI stage.
  task automatic step();
    @(negedge clk);
    cyc++;
    spi_done = 1'b0;
    if (spi_start) begin
      word_log.push_back(spi_word);
      if (start_first < 0) start_first = cyc;
      resp_cnt = resp_delay;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0 && resp_en) spi_done = 1'b1;
    end
    if (!ldac_n) ldac_low++;
    if (!ldac_n && ldac_prev) ldac_pulses++;
    ldac_prev = ldac_n;
    if (frames_sent != frames_prev) frame_cyc_q.push_back(cyc);
    frames_prev = frames_sent;
  endtask

  task automatic push(input logic [11:0] a, input logic [11:0] b, output int acc_cyc);
    s_valid = 1'b1;
    s_data  = {b, a};
    acc_cyc = -1;
    for (int i = 0; i < 600; i++) begin
      if (s_ready) begin
        step();
        acc_cyc = cyc;
        break;
      end
      step();
    end
    s_valid = 1'b0;
    chk("push_accepted", 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic wait_frames(input logic [15:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (frames_sent == target) break;
      step();
    end
    chk("frames_sent", 32'(frames_sent), 32'(target));
  endtask

  task automatic clear_logs();
    word_log.delete();
    frame_cyc_q.delete();
    start_first = -1;
    ldac_low    = 0;
    ldac_pulses = 0;
  endtask

  initial begin
    int acc;
    int accs[6];
    logic rdy_full;

    vecs[0] = '{12'h123, 12'hABC, 1'b1, 1'b0, 1'b0, 16'h3123, 16'hBABC};
    vecs[1] = '{12'hFFF, 12'h000, 1'b1, 1'b0, 1'b1, 16'h2FFF, 16'hA000};
    vecs[2] = '{12'h000, 12'hFFF, 1'b0, 1'b1, 1'b0, 16'h5000, 16'hDFFF};
    vecs[3] = '{12'h5A5, 12'hA5A, 1'b0, 1'b0, 1'b1, 16'h05A5, 16'h8A5A};
    vecs[4] = '{12'hFFF, 12'hFFF, 1'b1, 1'b1, 1'b0, 16'h7FFF, 16'hFFFF};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; spi_done = 1'b0;
    gain_1x = 1'b1; buffered = 1'b0; shdn = 1'b0;

    // Reset values
    repeat (3) step();
    chk("s_ready_in_reset", 32'(s_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_spi_word", 32'(spi_word), 32'h0);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_ldac_n", 32'(ldac_n), 32'd1);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // Table of single frames with various control-bit combinations
    for (int v = 0; v < 5; v++) begin
      gain_1x = vecs[v].gain; buffered = vecs[v].buff; shdn = vecs[v].sd;
      clear_logs();
      push(vecs[v].a, vecs[v].b, acc);
      wait_frames(16'(v + 1), 300);
      chk("start_latency", 32'(start_first), 32'(acc + 1));
      chk("n_starts", 32'(word_log.size()), 32'd2);
      if (word_log.size() >= 2) begin
        chk("word_a", 32'(word_log[0]), 32'(vecs[v].exp_a));
        chk("word_b", 32'(word_log[1]), 32'(vecs[v].exp_b));
      end
      chk("ldac_low_cycles", 32'(ldac_low), 32'd2);
      chk("ldac_pulses", 32'(ldac_pulses), 32'd1);
      chk("idle_spi_word", 32'(spi_word), 32'h0);
    end

    // Control bits toggled mid-frame must not affect the frame in flight
    gain_1x = 1'b1; buffered = 1'b0; shdn = 1'b1;
    clear_logs();
    push(12'hFFF, 12'h123, acc);
    step();
    gain_1x = 1'b0; buffered = 1'b1; shdn = 1'b0;
    wait_frames(16'd6, 300);
    chk("toggle_n_starts", 32'(word_log.size()), 32'd2);
    if (word_log.size() >= 2) begin
      chk("toggle_word_a", 32'(word_log[0]), 32'h2FFF);
      chk("toggle_word_b", 32'(word_log[1]), 32'hA123);
    end

    // Back-pressure: one pair in flight plus four queued fills the FIFO
    gain_1x = 1'b1; buffered = 1'b0; shdn = 1'b0;
    resp_delay = 40;
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      push(12'h100 + 12'(i), 12'h200 + 12'(i), acc);
      accs[i] = acc;
      if (i == 4) rdy_full = s_ready;
    end
    chk("bp_back_to_back", 32'(accs[4] - accs[0]), 32'd4);
    chk("bp_ready_low_when_full", 32'(rdy_full), 32'd0);
    chk("bp_frames_seen", 32'(frame_cyc_q.size() > 0), 32'd1);
    if (frame_cyc_q.size() > 0)
      chk("bp_last_push_after_pop", 32'(accs[5]), 32'(frame_cyc_q[0] + 2));
    wait_frames(16'd12, 2000);
    chk("bp_n_starts", 32'(word_log.size()), 32'd12);
    if (word_log.size() >= 12) begin
      for (int i = 0; i < 6; i++) begin
        chk("bp_word_a", 32'(word_log[2*i]),   32'(16'h3100 + 16'(i)));
        chk("bp_word_b", 32'(word_log[2*i+1]), 32'(16'hB200 + 16'(i)));
      end
    end

    // Timeout: spi_done never returns after the first start
    resp_delay = 16;
    resp_en = 1'b0;
    clear_logs();
    push(12'h321, 12'h654, acc);
    for (int i = 0; i < 10; i++) begin
      if (start_first >= 0) break;
      step();
    end
    chk("to_start_seen", 32'(start_first >= 0), 32'd1);
    repeat (64) step();
    chk("to_err_before", 32'(err_timeout), 32'd0);
    step();
    chk("to_err_set", 32'(err_timeout), 32'd1);
    chk("to_spi_word_zero", 32'(spi_word), 32'h0);
    repeat (5) step();
    chk("to_one_start", 32'(word_log.size()), 32'd1);
    chk("to_no_ldac", 32'(ldac_pulses), 32'd0);
    chk("to_frames_unchanged", 32'(frames_sent), 32'd12);
    resp_en = 1'b1;
    clear_logs();
    push(12'h111, 12'h222, acc);
    wait_frames(16'd13, 300);
    if (word_log.size() >= 2) begin
      chk("to_next_word_a", 32'(word_log[0]), 32'h3111);
      chk("to_next_word_b", 32'(word_log[1]), 32'hB222);
    end
    chk("to_err_sticky", 32'(err_timeout), 32'd1);

    // Reset while in WAIT_B with two pairs queued
    resp_delay = 30;
    clear_logs();
    for (int i = 0; i < 3; i++) push(12'h7A0 + 12'(i), 12'h5B0 + 12'(i), acc);
    for (int i = 0; i < 100; i++) begin
      if (word_log.size() >= 2) break;
      step();
    end
    chk("rb_reached_send_b", 32'(word_log.size()), 32'd2);
    step();
    reset = 1'b1;
    step();
    chk("rb_ldac_n", 32'(ldac_n), 32'd1);
    chk("rb_spi_start", 32'(spi_start), 32'd0);
    chk("rb_spi_word", 32'(spi_word), 32'h0);
    reset = 1'b0;
    resp_cnt = 0;
    clear_logs();
    repeat (20) step();
    chk("rb_fifo_empty_ready", 32'(s_ready), 32'd1);
    chk("rb_no_starts", 32'(word_log.size()), 32'd0);
    chk("rb_frames", 32'(frames_sent), 32'd0);
    chk("rb_err_cleared", 32'(err_timeout), 32'd0);

    // frames_sent wrap 0xFFFF -> 0
    resp_delay = 4;
    force dut.frames_q = 16'hFFFF;
    step();
    release dut.frames_q;
    step();
    chk("wrap_preload", 32'(frames_sent), 32'hFFFF);
    clear_logs();
    push(12'h0AA, 12'h055, acc);
    wait_frames(16'h0000, 300);
    chk("wrap_n_starts", 32'(word_log.size()), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
